// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy serial-pattern detector with saturating match counter
module seq_detector_param #(
   parameter int                     PATTERN_LEN     = 5,
   parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = PATTERN_LEN'(5'b10101),
   parameter int                     COUNT_W         = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_in,
   input  logic                   in_valid,
   input  logic                   overlap_en,
   input  logic                   cfg_load,
   input  logic [PATTERN_LEN-1:0] cfg_pattern,
   input  logic                   count_clr,
   output logic                   data_out,
   output logic [COUNT_W-1:0]     match_count
);

   // fill runs 0..N-1, so clog2(N) bits are always enough for N in 2..32
   localparam int                 FILL_W   = $clog2(PATTERN_LEN);
   localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PATTERN_LEN - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

   logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
   logic [PATTERN_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic [COUNT_W-1:0]     count_q, count_d;

   // window = stored history plus the bit on the wire; its low N-1 bits become the new history
   logic [PATTERN_LEN-1:0] window;
   logic                   match;

   assign window = {hist_q, data_in};

   // Mealy match: only a fully primed history with an accepted bit can complete the pattern
   always_comb begin
      match = 1'b0;
      if (!rst && in_valid && !cfg_load && (fill_q == FILL_MAX) && (window == pattern_q)) begin
         match = 1'b1;
      end
   end

   assign data_out    = match;
   assign match_count = count_q;

   // next state for pattern, history and fill; cfg_load takes priority and drops the stream bit
   always_comb begin
      pattern_d = pattern_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      if (cfg_load) begin
         pattern_d = cfg_pattern;
         fill_d    = '0;
      end else if (in_valid) begin
         hist_d = window[PATTERN_LEN-2:0];
         if (match && !overlap_en) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // saturating counter; a clear coincident with a match leaves the counter at one
   always_comb begin
      count_d = count_q;
      if (count_clr) begin
         count_d = match ? COUNT_W'(1) : '0;
      end else if (match && (count_q != CNT_MAX)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   // state registers with asynchronous reset to the default pattern and empty history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= DEFAULT_PATTERN;
         hist_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
      end else begin
         pattern_q <= pattern_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - table-driven bench for seq_detector_param (N=5, COUNT_W 8 and 2)
module tb_seq_detector_param;

   logic       clk;
   logic       rst;
   logic       data_in;
   logic       in_valid;
   logic       overlap_en;
   logic       cfg_load;
   logic [4:0] cfg_pattern;
   logic       count_clr;
   logic       data_out;
   logic       data_out2;
   logic [7:0] match_count;
   logic [1:0] match_count2;

   int n_cmp;
   int n_fail;

   seq_detector_param #(.PATTERN_LEN(5), .DEFAULT_PATTERN(5'b10101), .COUNT_W(8)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
      .overlap_en(overlap_en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .count_clr(count_clr), .data_out(data_out), .match_count(match_count)
   );

   seq_detector_param #(.PATTERN_LEN(5), .DEFAULT_PATTERN(5'b10101), .COUNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
      .overlap_en(overlap_en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .count_clr(count_clr), .data_out(data_out2), .match_count(match_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic       d;
      logic       ov;
      logic       ld;
      logic [4:0] pat;
      logic       clr;
      logic       exp_out;
      int         exp_cnt;
      int         exp_cnt2;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic v, logic d, logic ov, logic ld, logic [4:0] pat,
                               logic clr, logic e, int c1, int c2);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.ov = ov; t.ld = ld; t.pat = pat;
      t.clr = clr; t.exp_out = e; t.exp_cnt = c1; t.exp_cnt2 = c2;
      return t;
   endfunction

   task automatic add(logic r, logic v, logic d, logic ov, logic ld, logic [4:0] pat,
                      logic clr, logic e, int c1, int c2);
      tbl.push_back(mk(r, v, d, ov, ld, pat, clr, e, c1, c2));
   endtask

   task automatic chk(string nm, int id, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
      end
   endtask

   // drive one cycle just after a rising edge, check data_out mid-cycle, counts after the edge
   task automatic step(vec_t t, int id);
      rst         = t.rst;
      in_valid    = t.v;
      data_in     = t.d;
      overlap_en  = t.ov;
      cfg_load    = t.ld;
      cfg_pattern = t.pat;
      count_clr   = t.clr;
      #2;
      chk("data_out", id, int'(data_out), int'(t.exp_out));
      chk("data_out_w2", id, int'(data_out2), int'(t.exp_out));
      @(posedge clk);
      #1;
      if (t.exp_cnt >= 0)  chk("match_count", id, int'(match_count), t.exp_cnt);
      if (t.exp_cnt2 >= 0) chk("match_count_w2", id, int'(match_count2), t.exp_cnt2);
      rst = 1'b0;
   endtask

   task automatic bit_in(logic d, logic ov, logic e, int c1, int c2, int id);
      step(mk(1'b0, 1'b1, d, ov, 1'b0, 5'b10101, 1'b0, e, c1, c2), id);
   endtask

   initial begin
      logic [12:0] s13;
      logic [12:0] e_no;
      logic [12:0] e_ov;
      logic [14:0] s15;
      logic [14:0] e15;
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1; data_in = 1'b0; in_valid = 1'b0; overlap_en = 1'b0;
      cfg_load = 1'b0; cfg_pattern = 5'b0; count_clr = 1'b0;

      s13  = 13'b1010101010101;
      e_no = 13'b0000100000100;   // bits 5 and 11
      e_ov = 13'b0000101010101;   // bits 5,7,9,11,13
      s15  = 15'b101010101010101;
      e15  = 15'b000010101010101; // bits 5,7,9,11,13,15

      // test 1: non-overlap; reset row also checks reset counts
      add(1, 0, 0, 0, 0, 5'b10101, 0, 0, 0, 0);
      for (int i = 12; i >= 0; i--)
         add(0, 1, s13[i], 0, 0, 5'b10101, 0, e_no[i], (i == 0) ? 2 : -1, (i == 0) ? 2 : -1);
      // test 2: overlap; narrow counter saturates at 3
      add(1, 0, 0, 1, 0, 5'b10101, 0, 0, 0, 0);
      for (int i = 12; i >= 0; i--)
         add(0, 1, s13[i], 1, 0, 5'b10101, 0, e_ov[i], (i == 0) ? 5 : -1, (i == 0) ? 3 : -1);
      // test 3: stalls never break or fire a partial pattern
      add(1, 0, 0, 0, 0, 5'b10101, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 0, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 0, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 0, 1, 0, 0, 5'b10101, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 1, 1, 1);
      // primed history with a matching bit on a stalled cycle stays silent
      add(1, 0, 0, 0, 0, 5'b10101, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 0, 1, 0, 0, 5'b10101, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 1, 1, 1);
      // test 4: runtime pattern load drops the bit and restarts fill
      add(1, 0, 0, 0, 0, 5'b10101, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b10101, 0, 0, -1, -1);
      add(0, 1, 1, 0, 1, 5'b11011, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 5'b00000, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b00000, 0, 0, -1, -1);
      add(0, 1, 0, 0, 0, 5'b00000, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b00000, 0, 0, -1, -1);
      add(0, 1, 1, 0, 0, 5'b00000, 0, 1, 1, 1);
      for (int i = 4; i >= 0; i--)
         add(0, 1, i[0] ? 1'b0 : 1'b1, 0, 0, 5'b00000, 0, 0, (i == 0) ? 1 : -1, -1);
      // load with a stream bit present leaves the counter untouched
      add(0, 1, 1, 0, 1, 5'b10101, 0, 0, 1, 1);
      // test 6: six overlapping matches, narrow counter pinned at 3; clear with and without a match
      add(1, 0, 0, 1, 0, 5'b10101, 0, 0, 0, 0);
      for (int i = 14; i >= 0; i--)
         add(0, 1, s15[i], 1, 0, 5'b10101, 0, e15[i], (i == 0) ? 6 : -1, (i == 0) ? 3 : -1);
      add(0, 1, 0, 1, 0, 5'b10101, 0, 0, 6, 3);
      add(0, 1, 1, 1, 0, 5'b10101, 1, 1, 1, 1);
      add(0, 1, 0, 1, 0, 5'b10101, 1, 0, 0, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // test 5 with an asynchronous reset landing on a would-be match cycle
      step(mk(1, 0, 0, 0, 0, 5'b10101, 0, 0, 0, 0), 1000);
      bit_in(1, 0, 0, -1, -1, 1001);
      bit_in(0, 0, 0, -1, -1, 1002);
      bit_in(1, 0, 0, -1, -1, 1003);
      bit_in(0, 0, 0, 0, 0, 1004);
      data_in  = 1'b1;
      in_valid = 1'b1;
      #2;
      chk("data_out_primed", 1005, int'(data_out), 1);
      rst = 1'b1;
      #1;
      chk("data_out_in_rst", 1006, int'(data_out), 0);
      chk("count_in_rst", 1006, int'(match_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bit_in(1, 0, 0, 0, 0, 1007);
      bit_in(1, 0, 0, -1, -1, 1008);
      bit_in(0, 0, 0, -1, -1, 1009);
      bit_in(1, 0, 0, -1, -1, 1010);
      bit_in(0, 0, 0, -1, -1, 1011);
      bit_in(1, 0, 1, 1, 1, 1012);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
